// File: rtl/hwpe_stream_tcdm_reader.sv
// hwpe_stream_tcdm_reader
// Turns an address stream into TCDM read requests and streams the read data
// back out in order. It keeps at most MAX_OUTSTANDING beats either in flight
// or buffered, so the response FIFO can never overflow. It also raises a
// one-cycle done pulse after the last beat of a transfer of tot_len_i beats.
module hwpe_stream_tcdm_reader #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TRANS_CNT       = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clear_i,
  // address stream from the address generator
  input  logic                    addr_valid_i,
  input  logic [31:0]             addr_data_i,
  output logic                    addr_ready_o,
  // TCDM master port
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [31:0]             tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  input  logic                    tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  // output data stream
  output logic                    data_valid_o,
  input  logic                    data_ready_i,
  output logic [DATA_WIDTH-1:0]   data_data_o,
  output logic [DATA_WIDTH/8-1:0] data_strb_o,
  // transfer control
  input  logic [TRANS_CNT-1:0]    tot_len_i,
  output logic                    done_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [TRANS_CNT-1:0]  out_cnt_q,  out_cnt_d;
  logic                  done_q,     done_d;
  logic                  drop_q,     drop_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [MAX_OUTSTANDING];

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic [CNT_W:0] occupancy;
  logic           has_credit;
  logic           grant;
  logic           rsp_accept;
  logic           rsp_retire;
  logic           push;
  logic           pop;
  logic           fifo_full;

  // credit = MAX_OUTSTANDING - inflight - fifo_count, evaluated as occupancy < MAX
  assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign has_credit = occupancy < (CNT_W + 1)'(MAX_OUTSTANDING);

  // rst_ni keeps the request low while reset is held, even if upstream is valid
  assign tcdm_req_o   = rst_ni & addr_valid_i & enable_i & has_credit & ~clear_i;
  assign grant        = tcdm_req_o & tcdm_gnt_i;
  assign addr_ready_o = grant;

  // Address comes straight from the stream; upstream holds it until the grant
  assign tcdm_add_o  = addr_data_i;
  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = '1;
  assign tcdm_data_o = '0;

  // A response in the cycle of a clear, or in the cycle after it, is stale
  assign rsp_accept = tcdm_r_valid_i & ~drop_q & ~clear_i;
  assign rsp_retire = tcdm_r_valid_i & ~drop_q & (inflight_q != '0);

  assign fifo_full    = (fifo_cnt_q == MAX_CNT);
  assign data_valid_o = (fifo_cnt_q != '0);
  assign data_data_o  = fifo_mem_q[rd_ptr_q];
  assign data_strb_o  = '1;
  assign done_o       = done_q;

  assign pop  = data_valid_o & data_ready_i;
  // A full FIFO still accepts a beat when it pops in the same cycle
  assign push = rsp_accept & (~fifo_full | pop);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------

  // Count read requests granted but not yet answered
  always_comb begin
    inflight_d = inflight_q;
    if (clear_i) begin
      inflight_d = '0;
    end else begin
      unique case ({grant, rsp_retire})
        2'b10:   inflight_d = inflight_q + CNT_W'(1);
        2'b01:   inflight_d = inflight_q - CNT_W'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // Response FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  // Count delivered beats and flag the last one of the transfer
  always_comb begin
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    if (clear_i) begin
      out_cnt_d = '0;
    end else if (pop) begin
      if ((tot_len_i != '0) && (out_cnt_q + TRANS_CNT'(1) == tot_len_i)) begin
        out_cnt_d = '0;
        done_d    = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + TRANS_CNT'(1);
      end
    end
  end

  // Remember a clear so the response that follows it is discarded
  assign drop_d = clear_i;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------

  // Control state with asynchronous reset
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  // Response storage, written on push
  // NOTE: the data array is not reset; fifo_cnt_q gates its visibility, so reset would only cost area.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= tcdm_r_data_i;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Self-checking bench for hwpe_stream_tcdm_reader: an address driver, a
// one-cycle-latency TCDM responder, and a scoreboard monitor on the output.
`timescale 1ns/1ps
module tb_hwpe_stream_tcdm_reader;

  localparam int DW = 32;
  localparam int MO = 4;
  localparam int TC = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i, clear_i;
  logic          addr_valid_i, addr_ready_o;
  logic [31:0]   addr_data_i;
  logic          tcdm_req_o, tcdm_gnt_i, tcdm_wen_o;
  logic [31:0]   tcdm_add_o;
  logic [DW/8-1:0] tcdm_be_o;
  logic [DW-1:0] tcdm_data_o;
  logic          tcdm_r_valid_i;
  logic [DW-1:0] tcdm_r_data_i;
  logic          data_valid_o, data_ready_i;
  logic [DW-1:0] data_data_o;
  logic [DW/8-1:0] data_strb_o;
  logic [TC-1:0] tot_len_i;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  hwpe_stream_tcdm_reader #(
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .TRANS_CNT(TC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
    .addr_valid_i(addr_valid_i), .addr_data_i(addr_data_i), .addr_ready_o(addr_ready_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .data_data_o(data_data_o), .data_strb_o(data_strb_o),
    .tot_len_i(tot_len_i), .done_o(done_o)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_seen = 0;
  logic [31:0] addr_q[$];
  logic [31:0] exp_q[$];
  bit          drv_en = 1'b0;
  bit          inject = 1'b0;
  logic [31:0] inj_data = '0;

  // Memory contents as seen by the bench: upper half is the inverted address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Wait for the datapath to empty, then give a done pulse time to show up
  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (addr_q.size() == 0 && exp_q.size() == 0 && !data_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", 32'(ok), 32'd1);
    repeat (2) @(negedge clk_i);
    step();
  endtask

  task automatic count_grants(input int cycles, output int grants);
    grants = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (tcdm_req_o && tcdm_gnt_i) grants++;
    end
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    exp_q.delete();
    step();
    clear_i = 1'b0;
    step();
  endtask

  // Address driver: presents the queue head, pushes the expected beat on grant
  initial begin
    bit hs;
    forever begin
      @(negedge clk_i);
      hs = drv_en && rst_ni && tcdm_req_o && tcdm_gnt_i && (addr_q.size() > 0);
      if (hs) begin
        check("tcdm_add_o", tcdm_add_o, addr_q[0]);
        check("addr_ready_o", 32'(addr_ready_o), 32'd1);
        exp_q.push_back(mem_f(addr_q[0]));
      end
      @(posedge clk_i);
      #2;
      if (drv_en) begin
        if (hs && addr_q.size() > 0) void'(addr_q.pop_front());
        addr_valid_i = (addr_q.size() > 0);
        addr_data_i  = (addr_q.size() > 0) ? addr_q[0] : 32'h0;
      end
    end
  end

  // TCDM responder: data one cycle after the grant, or an injected beat
  initial begin
    bit          g;
    logic [31:0] ga;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i  = '0;
    forever begin
      @(negedge clk_i);
      g  = rst_ni && tcdm_req_o && tcdm_gnt_i;
      ga = tcdm_add_o;
      @(posedge clk_i);
      #1;
      if (inject) begin
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = inj_data;
        exp_q.push_back(inj_data);
        inject = 1'b0;
      end else begin
        tcdm_r_valid_i = g;
        tcdm_r_data_i  = g ? mem_f(ga) : '0;
      end
    end
  end

  // Monitor: scoreboard on output handshakes and an independent done model
  initial begin
    int          hs_cnt = 0;
    bit          exp_done = 1'b0;
    logic [31:0] exp_beat;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        hs_cnt   = 0;
        exp_done = 1'b0;
      end else begin
        if (exp_done || done_o) check("done_o", 32'(done_o), 32'(exp_done));
        if (done_o) done_seen++;
        exp_done = 1'b0;
        if (clear_i) begin
          hs_cnt = 0;
        end else if (data_valid_o && data_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", data_data_o, 32'hxxxxxxxx);
          end else begin
            exp_beat = exp_q.pop_front();
            check("data_data_o", data_data_o, exp_beat);
            check("fifo_bound", 32'(exp_q.size() <= MO), 32'd1);
          end
          check("data_strb_o", 32'(data_strb_o), 32'hF);
          hs_cnt++;
          if (tot_len_i != 0 && hs_cnt == int'(tot_len_i)) begin
            hs_cnt   = 0;
            exp_done = 1'b1;
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    logic exp_val_a [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic exp_req_a [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic exp_done_a[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic exp_val_d [6] = '{1, 1, 1, 1, 1, 0};
    int   grants, d0;

    enable_i = 1'b1; clear_i = 1'b0; addr_valid_i = 1'b1; addr_data_i = 32'h40;
    tcdm_gnt_i = 1'b1; data_ready_i = 1'b1; tot_len_i = '0;

    // Reset state with a valid address already offered
    @(negedge clk_i);
    check("rst_req", 32'(tcdm_req_o), 32'd0);
    check("rst_addr_ready", 32'(addr_ready_o), 32'd0);
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("tcdm_wen_o", 32'(tcdm_wen_o), 32'd1);
    check("tcdm_be_o", 32'(tcdm_be_o), 32'hF);
    check("tcdm_data_o", tcdm_data_o, 32'd0);
    addr_valid_i = 1'b0;
    drv_en = 1'b1;
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    step();

    // A: four beats with grant and ready held high
    tot_len_i = 4;
    for (int i = 0; i < 4; i++) addr_q.push_back(32'h100 + 32'(4 * i));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      check($sformatf("A_req_c%0d", c), 32'(tcdm_req_o), 32'(exp_req_a[c]));
      check($sformatf("A_valid_c%0d", c), 32'(data_valid_o), 32'(exp_val_a[c]));
      check($sformatf("A_done_c%0d", c), 32'(done_o), 32'(exp_done_a[c]));
    end
    step();

    // B: ready low, six addresses -> four grants, then drain in order
    d0 = done_seen;
    data_ready_i = 1'b0; tot_len_i = 6;
    for (int i = 0; i < 6; i++) addr_q.push_back(32'h200 + 32'(4 * i));
    count_grants(8, grants);
    check("B_grants", 32'(grants), 32'd4);
    check("B_req_blocked", 32'(tcdm_req_o), 32'd0);
    check("B_valid_full", 32'(data_valid_o), 32'd1);
    step();
    data_ready_i = 1'b1;
    wait_idle(40);
    check("B_done_count", 32'(done_seen - d0), 32'd1);

    // C: grant withheld for three cycles, request held stable
    tcdm_gnt_i = 1'b0; tot_len_i = 0;
    addr_q.push_back(32'h300);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("C_req_c%0d", c), 32'(tcdm_req_o), 32'd1);
      check($sformatf("C_add_c%0d", c), tcdm_add_o, 32'h300);
      check($sformatf("C_ready_c%0d", c), 32'(addr_ready_o), 32'd0);
      check($sformatf("C_valid_c%0d", c), 32'(data_valid_o), 32'd0);
    end
    step();
    tcdm_gnt_i = 1'b1;
    wait_idle(20);

    // G: enable low blocks requests until raised again
    enable_i = 1'b0;
    addr_q.push_back(32'h900);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check($sformatf("G_req_c%0d", c), 32'(tcdm_req_o), 32'd0);
    end
    step();
    enable_i = 1'b1;
    wait_idle(20);
    clear_pulse();

    // D: full FIFO with a pop and a push in the same cycle
    data_ready_i = 1'b0; tot_len_i = 0;
    for (int i = 0; i < 4; i++) addr_q.push_back(32'h400 + 32'(4 * i));
    count_grants(7, grants);
    check("D_grants", 32'(grants), 32'd4);
    check("D_valid_full", 32'(data_valid_o), 32'd1);
    check("D_req_blocked", 32'(tcdm_req_o), 32'd0);
    inj_data = 32'hCAFE0005;
    inject = 1'b1;
    step();
    data_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      check($sformatf("D_valid_c%0d", c), 32'(data_valid_o), 32'(exp_val_d[c]));
    end
    step();
    clear_pulse();

    // E: clear one cycle after a grant drops the response and zeroes counters
    d0 = done_seen;
    tot_len_i = 1;
    addr_q.push_back(32'h500);
    @(negedge clk_i);
    check("E_grant", 32'(tcdm_req_o & tcdm_gnt_i), 32'd1);
    step();
    clear_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check("E_valid_clr", 32'(data_valid_o), 32'd0);
    step();
    clear_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("E_valid_c%0d", c), 32'(data_valid_o), 32'd0);
      check($sformatf("E_done_c%0d", c), 32'(done_o), 32'd0);
    end
    step();
    data_ready_i = 1'b0; tot_len_i = 4;
    for (int i = 0; i < 4; i++) addr_q.push_back(32'h600 + 32'(4 * i));
    count_grants(8, grants);
    check("E_grants_after_clear", 32'(grants), 32'd4);
    step();
    data_ready_i = 1'b1;
    wait_idle(30);
    check("E_done_count", 32'(done_seen - d0), 32'd1);

    // F: reset mid-transfer with two beats buffered, then a clean transfer
    data_ready_i = 1'b0; tot_len_i = 3;
    addr_q.push_back(32'h700);
    addr_q.push_back(32'h704);
    repeat (5) @(negedge clk_i);
    check("F_valid_buffered", 32'(data_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("F_valid_async", 32'(data_valid_o), 32'd0);
    check("F_req_rst", 32'(tcdm_req_o), 32'd0);
    check("F_done_rst", 32'(done_o), 32'd0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    step();
    d0 = done_seen;
    data_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) addr_q.push_back(32'h800 + 32'(4 * i));
    wait_idle(30);
    check("F_done_count", 32'(done_seen - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_tcdm_reader.md
HWPE_STREAM_TCDM_READER -- requirements
Module: hwpe_stream_tcdm_reader

Interface
REQ-001: Parameter DATA_WIDTH, default 32; width of the TCDM read data and of the output data stream.
REQ-002: Parameter MAX_OUTSTANDING, default 4; response buffer depth and the maximum number of read requests in flight.
REQ-003: Parameter TRANS_CNT, default 32; width of the transaction length and of the delivered-beat counter.
REQ-004: Port clk_i, input, 1; clock.
REQ-005: Port rst_ni, input, 1; reset, asynchronous, active-low.
REQ-006: Port enable_i, input, 1; local enable; when low, no requests are issued and internal state is held.
REQ-007: Port clear_i, input, 1; synchronous clear.
REQ-008: Port addr_valid_i, input, 1; upstream address stream valid, driven by the address generator.
REQ-009: Port addr_data_i, input, 32; byte address to read.
REQ-010: Port addr_ready_o, output, 1; address consumed this cycle.
REQ-011: Port tcdm_req_o, input/output direction output, 1; TCDM request.
REQ-012: Port tcdm_gnt_i, input, 1; TCDM grant.
REQ-013: Port tcdm_add_o, output, 32; request address, equal to addr_data_i.
REQ-014: Port tcdm_wen_o, output, 1; constant 1 (read).
REQ-015: Port tcdm_be_o, output, DATA_WIDTH/8; constant all-ones.
REQ-016: Port tcdm_data_o, output, DATA_WIDTH; constant 0.
REQ-017: Port tcdm_r_valid_i, input, 1; read response valid.
REQ-018: Port tcdm_r_data_i, input, DATA_WIDTH; read response data.
REQ-019: Port data_valid_o, output, 1; output stream valid.
REQ-020: Port data_ready_i, input, 1; output stream ready.
REQ-021: Port data_data_o, output, DATA_WIDTH; output stream data.
REQ-022: Port data_strb_o, output, DATA_WIDTH/8; constant all-ones.
REQ-023: Port tot_len_i, input, TRANS_CNT; number of beats in the transfer.
REQ-024: Port done_o, output, 1; single-cycle pulse when the last beat leaves on the output stream.

Function
REQ-025: inflight counter (0..MAX_OUTSTANDING): incremented on each grant, decremented on each tcdm_r_valid_i.
REQ-026: credit = MAX_OUTSTANDING - inflight - fifo_count.
REQ-027: tcdm_req_o = addr_valid_i & enable_i & (credit > 0) & ~clear_i.
REQ-028: addr_ready_o = tcdm_req_o & tcdm_gnt_i.
REQ-029: The request and address are held stable while tcdm_req_o=1 and tcdm_gnt_i=0.
REQ-030: tcdm_r_valid_i arrives exactly one cycle after the grant; tcdm_r_data_i is then pushed into the response FIFO (depth MAX_OUTSTANDING).
REQ-031: The FIFO never overflows; an overflow is an assertion failure in the bench.
REQ-032: data_valid_o = FIFO not empty; data_data_o = FIFO head; the FIFO pops on data_valid_o & data_ready_i.
REQ-033: Push and pop in the same cycle leave fifo_count unchanged, including when the FIFO is full.
REQ-034: Latency from grant in cycle N to data_valid_o is cycle N+2, with no backpressure.
REQ-035: Throughput is one beat per cycle with continuous grant and ready.
REQ-036: The out-counter increments on each output handshake.
REQ-037: done_o=1 for exactly one cycle, in the cycle after the handshake that makes out-counter equal tot_len_i; the out-counter then resets to 0.
REQ-038: tot_len_i=0: no done_o is generated, and requests are not gated by length (the upstream stream bounds length).
REQ-039: enable_i=0: tcdm_req_o=0 and counters hold; responses already in flight are still captured into the FIFO; output pops still occur.
REQ-040: clear_i=1: FIFO, inflight, and out-counter are cleared to 0 in the next cycle.
REQ-041: A response arriving in the cycle after clear_i is discarded.
REQ-042: If clear_i coincides with a handshake, clear wins.

Reset
REQ-043: On rst_ni low, asynchronously: FIFO empty, inflight=0, out-counter=0.
REQ-044: During reset: data_valid_o=0, tcdm_req_o=0, addr_ready_o=0, done_o=0.
REQ-045: Operation is allowed from the first clock edge after rst_ni rises.

Verification
REQ-046: tot_len_i=4, addresses 0x100..0x10C, gnt and ready always 1 -> four requests in consecutive cycles, data out at N+2..N+5, done_o pulse one cycle after the 4th output.
REQ-047: MAX_OUTSTANDING=4, data_ready_i=0 with 6 addresses offered -> exactly 4 grants, then tcdm_req_o=0; releasing ready drains all 6 in order.
REQ-048: tcdm_gnt_i=0 for 3 cycles with addr_valid_i=1 -> tcdm_req_o and tcdm_add_o stable, addr_ready_o=0, no FIFO push.
REQ-049: FIFO full plus simultaneous pop and r_valid push -> count stays 4 and ordering is preserved.
REQ-050: clear_i one cycle after a grant -> the response is dropped, data_valid_o=0, and the counters are 0.
REQ-051: rst_ni asserted mid-transfer with 2 beats buffered -> data_valid_o falls immediately, and after release the next transfer completes with the correct done_o pulse.
